reg_list_sequencer: RTL and testbench

// - Multi-register transfer controller (PUSH/POP, LDM/STM) between the clocked reg file and data memory.
// - Walks a 16-bit register list one register at a time in ascending register order.
// - Drives reg file read/write ports and a single req/ready memory port.
// - Stalls the pipeline while active; returns the final base address for write-back.

---
 rtl/reg_list_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_reg_list_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_list_sequencer.sv
// Multi-register transfer sequencer (PUSH/POP, LDM/STM) between register file and data memory.
// Optional SEQ_PC_LOAD_EN: loads of R15 are redirected to pc_load_o/pc_value_o instead of the reg file.
module reg_list_sequencer #(
  parameter int DATA_W = 32,
  parameter int LIST_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              is_load_i,
  input  logic              decrement_i,
  input  logic [LIST_W-1:0] reg_list_i,
  input  logic [DATA_W-1:0] base_addr_i,
  output logic [ADDR_W-1:0] rf_read_addr_o,
  input  logic [DATA_W-1:0] rf_read_data_i,
  output logic              rf_write_en_o,
  output logic [ADDR_W-1:0] rf_write_addr_o,
  output logic [DATA_W-1:0] rf_write_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] final_addr_o
`ifdef SEQ_PC_LOAD_EN
  ,
  output logic              pc_load_o,
  output logic [DATA_W-1:0] pc_value_o
`endif
);

  localparam int CNT_W = $clog2(LIST_W + 1);
`ifdef SEQ_PC_LOAD_EN
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(15);
`endif

  typedef enum logic [2:0] {IDLE, S_RD, S_WR, L_REQ, L_WB, DONE} state_t;

  state_t              state;
  logic [LIST_W-1:0]   list_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_first;

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   span;
  logic [DATA_W-1:0]   base_lo;
  logic [LIST_W-1:0]   list_next;
  logic [ADDR_W-1:0]   low_idx;
  logic [ADDR_W-1:0]   low_next;
  logic [ADDR_W-1:0]   low_start;

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] l);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < LIST_W; i++) c = c + CNT_W'(l[i]);
    return c;
  endfunction

  function automatic logic [ADDR_W-1:0] lowest(input logic [LIST_W-1:0] l);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int unsigned i = LIST_W; i > 0; i--) if (l[i-1]) idx = ADDR_W'(i - 1);
    return idx;
  endfunction

  assign cnt       = popcount(reg_list_i);
  assign span      = DATA_W'(cnt) << 2;
  assign base_lo   = base_addr_i - span;
  assign list_next = list_q & (list_q - LIST_W'(1));
  assign low_idx   = lowest(list_q);
  assign low_next  = lowest(list_next);
  assign low_start = lowest(reg_list_i);

  // Read data arrives in the first S_WR cycle; pass it straight through, then hold the captured copy.
  assign mem_wdata_o = wr_first ? rf_read_data_i : data_q;
  assign stall_o     = (state != IDLE) | (start_i & (state == IDLE));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= IDLE;
      list_q          <= '0;
      data_q          <= '0;
      wr_first        <= 1'b0;
      rf_read_addr_o  <= '0;
      rf_write_en_o   <= 1'b0;
      rf_write_addr_o <= '0;
      rf_write_data_o <= '0;
      mem_req_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      done_o          <= 1'b0;
      final_addr_o    <= '0;
`ifdef SEQ_PC_LOAD_EN
      pc_load_o       <= 1'b0;
      pc_value_o      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            list_q       <= reg_list_i;
            mem_addr_o   <= decrement_i ? base_lo : base_addr_i;
            final_addr_o <= decrement_i ? base_lo : base_addr_i + span;
            if (cnt == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (is_load_i) begin
              state     <= L_REQ;
              mem_req_o <= 1'b1;
              mem_we_o  <= 1'b0;
            end else begin
              state          <= S_RD;
              rf_read_addr_o <= low_start;
            end
          end
        end
        S_RD: begin
          state     <= S_WR;
          mem_req_o <= 1'b1;
          mem_we_o  <= 1'b1;
          wr_first  <= 1'b1;
        end
        S_WR: begin
          wr_first <= 1'b0;
          if (wr_first) data_q <= rf_read_data_i;
          if (mem_ready_i) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            list_q     <= list_next;
            mem_addr_o <= mem_addr_o + DATA_W'(4);
            if (list_next == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state          <= S_RD;
              rf_read_addr_o <= low_next;
            end
          end
        end
        L_REQ: begin
          if (mem_ready_i) begin
            mem_req_o       <= 1'b0;
            state           <= L_WB;
            rf_write_addr_o <= low_idx;
            rf_write_data_o <= mem_rdata_i;
            rf_write_en_o   <= 1'b1;
`ifdef SEQ_PC_LOAD_EN
            if (low_idx == PC_IDX) begin
              rf_write_en_o <= 1'b0;
              pc_load_o     <= 1'b1;
              pc_value_o    <= {mem_rdata_i[DATA_W-1:1], 1'b0};
            end
`endif
          end
        end
        L_WB: begin
          rf_write_en_o <= 1'b0;
`ifdef SEQ_PC_LOAD_EN
          pc_load_o     <= 1'b0;
`endif
          list_q     <= list_next;
          mem_addr_o <= mem_addr_o + DATA_W'(4);
          if (list_next == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            state     <= L_REQ;
            mem_req_o <= 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed self-checking bench for reg_list_sequencer: reg file / memory models plus linear test steps.
module tb_reg_list_sequencer;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        is_load_i = 1'b0;
  logic        decrement_i = 1'b0;
  logic [15:0] reg_list_i = '0;
  logic [31:0] base_addr_i = '0;
  logic [3:0]  rf_read_addr_o;
  logic [31:0] rf_read_data_i;
  logic        rf_write_en_o;
  logic [3:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] final_addr_o;
`ifdef SEQ_PC_LOAD_EN
  logic        pc_load_o;
  logic [31:0] pc_value_o;
`endif

  reg_list_sequencer #(.DATA_W(32), .LIST_W(16), .ADDR_W(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .is_load_i(is_load_i),
    .decrement_i(decrement_i), .reg_list_i(reg_list_i), .base_addr_i(base_addr_i),
    .rf_read_addr_o(rf_read_addr_o), .rf_read_data_i(rf_read_data_i),
    .rf_write_en_o(rf_write_en_o), .rf_write_addr_o(rf_write_addr_o),
    .rf_write_data_o(rf_write_data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .done_o(done_o),
    .final_addr_o(final_addr_o)
`ifdef SEQ_PC_LOAD_EN
    , .pc_load_o(pc_load_o), .pc_value_o(pc_value_o)
`endif
  );

  always #5 clk = ~clk;

  // Register file contents; r0/r2 carry the values the PUSH example expects.
  logic [31:0] regs [16] = '{32'h11, 32'hA000_0001, 32'h22, 32'hA000_0003,
                             32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007,
                             32'hA000_0008, 32'hA000_0009, 32'hA000_000A, 32'hA000_000B,
                             32'hA000_000C, 32'hA000_000D, 32'hA000_000E, 32'hA000_000F};
  logic [31:0] ld_data [64];
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cnt = 0;
  int          rfw_cnt = 0;
  int          ld_idx = 0;
  int          pc_cnt = 0;
  logic [31:0] pc_last = '0;
  logic        excl_bad = 1'b0;

  always @(posedge clk) rf_read_data_i <= regs[rf_read_addr_o];
  assign mem_rdata_i = ld_data[ld_idx];

  // Observe at negedge: values are stable and will be consumed at the next rising edge.
  always @(negedge clk) begin
    if (rf_write_en_o && mem_req_o) excl_bad = 1'b1;
    if (mem_req_o && mem_we_o && mem_ready_i && wr_cnt < 64) begin
      wr_addr[wr_cnt] = mem_addr_o;
      wr_data[wr_cnt] = mem_wdata_o;
      wr_cnt++;
    end
    if (rf_write_en_o) begin
      regs[rf_write_addr_o] = rf_write_data_o;
      rfw_cnt++;
    end
`ifdef SEQ_PC_LOAD_EN
    if (pc_load_o) begin
      pc_cnt++;
      pc_last = pc_value_o;
    end
`endif
    if (mem_req_o && !mem_we_o && mem_ready_i) begin
      @(posedge clk);
      #1 ld_idx++;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic load, input logic dec, input logic [15:0] list,
                          input logic [31:0] base);
    is_load_i   = load;
    decrement_i = dec;
    reg_list_i  = list;
    base_addr_i = base;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   {31'd0, mem_req_o},     32'd0);
    check({tag, "_we"},    {31'd0, mem_we_o},      32'd0);
    check({tag, "_rfwe"},  {31'd0, rf_write_en_o}, 32'd0);
    check({tag, "_done"},  {31'd0, done_o},        32'd0);
    check({tag, "_stall"}, {31'd0, stall_o},       32'd0);
    check({tag, "_addr"},  mem_addr_o,             32'd0);
    check({tag, "_wdata"}, mem_wdata_o,            32'd0);
    check({tag, "_final"}, final_addr_o,           32'd0);
    check({tag, "_rfwa"},  {28'd0, rf_write_addr_o}, 32'd0);
    check({tag, "_rfra"},  {28'd0, rf_read_addr_o},  32'd0);
  endtask

  initial begin
    logic        ok;
    int          w0;
    int          r0;
    logic [31:0] d0;
    logic [31:0] a0;
    logic [31:0] exp_data [16];

    for (int i = 0; i < 64; i++) ld_data[i] = '0;

    // Reset state
    #1;
    check_idle_outputs("reset");
    repeat (2) tick();
    reset_n_i = 1'b1;
    tick();

    // Empty list: straight to DONE, no traffic
    w0 = wr_cnt; r0 = rfw_cnt;
    start_op(1'b0, 1'b0, 16'h0000, 32'h40);
    check("empty_done", {31'd0, done_o}, 32'd1);
    check("empty_final", final_addr_o, 32'h40);
    check("empty_stall", {31'd0, stall_o}, 32'd1);
    check("empty_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    check("empty_done_pulse", {31'd0, done_o}, 32'd0);
    check("empty_stall_off", {31'd0, stall_o}, 32'd0);
    check("empty_no_writes", wr_cnt - w0, 32'd0);
    check("empty_no_rfw", rfw_cnt - r0, 32'd0);

    // PUSH {r0,r2}, descending from 0x100, zero wait states
    mem_ready_i = 1'b1;
    w0 = wr_cnt;
    start_op(1'b0, 1'b1, 16'h0005, 32'h100);
    wait_done(20, ok);
    check("push_done_seen", {31'd0, ok}, 32'd1);
    check("push_final", final_addr_o, 32'hF8);
    check("push_stall_in_done", {31'd0, stall_o}, 32'd1);
    check("push_nwr", wr_cnt - w0, 32'd2);
    check("push_a0", wr_addr[w0], 32'hF8);
    check("push_d0", wr_data[w0], 32'h11);
    check("push_a1", wr_addr[w0+1], 32'hFC);
    check("push_d1", wr_data[w0+1], 32'h22);
    tick();

    // Store of r1 with memory stalled 3 cycles; start pulse in the middle is ignored
    mem_ready_i = 1'b0;
    w0 = wr_cnt;
    start_op(1'b0, 1'b0, 16'h0002, 32'h200);
    tick();
    check("stall_req", {31'd0, mem_req_o}, 32'd1);
    check("stall_we", {31'd0, mem_we_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_addr", mem_addr_o, 32'h200);
      check("stall_hold_wdata", mem_wdata_o, 32'hA000_0001);
      check("stall_hold_req", {31'd0, mem_req_o}, 32'd1);
      check("stall_hold_rfra", {28'd0, rf_read_addr_o}, 32'd1);
      if (i == 1) begin
        is_load_i = 1'b1; reg_list_i = 16'hFFFF; base_addr_i = 32'h5000; start_i = 1'b1;
      end
      tick();
      start_i = 1'b0;
    end
    mem_ready_i = 1'b1;
    wait_done(20, ok);
    check("stall_done_seen", {31'd0, ok}, 32'd1);
    check("stall_final", final_addr_o, 32'h204);
    check("stall_nwr", wr_cnt - w0, 32'd1);
    check("stall_d0", wr_data[w0], 32'hA000_0001);
    repeat (3) tick();
    check("stall_ignored_req", {31'd0, mem_req_o}, 32'd0);
    check("stall_ignored_idle", {31'd0, stall_o}, 32'd0);

    // POP {r1,r15}, ascending from 0xF8
    ld_data[ld_idx]     = 32'hAA;
    ld_data[ld_idx + 1] = 32'hBD;
    r0 = rfw_cnt;
    start_op(1'b1, 1'b0, 16'h8002, 32'hF8);
    wait_done(20, ok);
    check("pop_done_seen", {31'd0, ok}, 32'd1);
    check("pop_final", final_addr_o, 32'h100);
    check("pop_r1", regs[1], 32'hAA);
`ifdef SEQ_PC_LOAD_EN
    check("pop_nrfw", rfw_cnt - r0, 32'd1);
    check("pop_pc_cnt", pc_cnt, 32'd1);
    check("pop_pc_value", pc_last, 32'hBC);
    check("pop_r15_kept", regs[15], 32'hA000_000F);
`else
    check("pop_nrfw", rfw_cnt - r0, 32'd2);
    check("pop_r15", regs[15], 32'hBD);
    check("pop_pc_cnt", pc_cnt, 32'd0);
`endif
    tick();

    // STM all 16 registers, descending from 0x1000
    for (int k = 0; k < 16; k++) exp_data[k] = regs[k];
    w0 = wr_cnt;
    start_op(1'b0, 1'b1, 16'hFFFF, 32'h1000);
    wait_done(100, ok);
    check("stm_done_seen", {31'd0, ok}, 32'd1);
    check("stm_final", final_addr_o, 32'hFC0);
    check("stm_nwr", wr_cnt - w0, 32'd16);
    for (int k = 0; k < 16; k++) begin
      a0 = 32'hFC0 + 32'(4 * k);
      check("stm_addr", wr_addr[w0+k], a0);
      check("stm_data", wr_data[w0+k], exp_data[k]);
    end
    tick();

    // Reset asserted while the 2nd of 3 loads is pending
    mem_ready_i = 1'b0;
    ld_data[ld_idx]     = 32'h33;
    ld_data[ld_idx + 1] = 32'h44;
    ld_data[ld_idx + 2] = 32'h55;
    d0 = regs[4];
    start_op(1'b1, 1'b0, 16'h0038, 32'h300);
    check("rst_req1", {31'd0, mem_req_o}, 32'd1);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    tick();
    check("rst_req2", {31'd0, mem_req_o}, 32'd1);
    check("rst_addr2", mem_addr_o, 32'h304);
    reset_n_i = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_r3_kept", regs[3], 32'h33);
    check("rst_r4_untouched", regs[4], d0);
    tick();
    reset_n_i = 1'b1;
    tick();
    check("rst_idle_stall", {31'd0, stall_o}, 32'd0);

    // Normal transfer after reset
    mem_ready_i = 1'b1;
    w0 = wr_cnt;
    start_op(1'b0, 1'b0, 16'h0040, 32'h400);
    wait_done(20, ok);
    check("post_done_seen", {31'd0, ok}, 32'd1);
    check("post_final", final_addr_o, 32'h404);
    check("post_nwr", wr_cnt - w0, 32'd1);
    check("post_a0", wr_addr[w0], 32'h400);
    check("post_d0", wr_data[w0], 32'hA000_0006);
    tick();

    check("rfwe_req_exclusive", {31'd0, excl_bad}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
